decode_stage: RTL

// - IF->EX pipeline stage that drives the ALU operand/select interface.
// - Accepts a fetched RV32I instruction+PC over a valid/ready handshake and decodes it

---
 rtl/decode_stage.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I integer decode + 32-entry register file feeding the EX operand interface.
// Latency: one cycle from IF accept to registered EX outputs; one instruction per cycle max.
// Backpressure: if_ready drops while EX holds a valid word unconsumed; ex_* hold stable meanwhile.
// Optional feature macro: ID_WB_BYPASS_EN (writeback-to-operand bypass in the accept cycle).

package alu_pkg;
  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XXOR  = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OOR   = 5'd8;
  localparam logic [4:0] ALU_AAND  = 5'd9;
  localparam logic [4:0] ALU_ADDI  = 5'd10;
  localparam logic [4:0] ALU_SLTI  = 5'd11;
  localparam logic [4:0] ALU_SLTIU = 5'd12;
  localparam logic [4:0] ALU_XORI  = 5'd13;
  localparam logic [4:0] ALU_ORI   = 5'd14;
  localparam logic [4:0] ALU_ANDI  = 5'd15;
  localparam logic [4:0] ALU_SLLI  = 5'd16;
  localparam logic [4:0] ALU_SRLI  = 5'd17;
  localparam logic [4:0] ALU_SRAI  = 5'd18;
  localparam logic [4:0] ALU_LUI   = 5'd19;
  localparam logic [4:0] ALU_AUIPC = 5'd20;
endpackage

module decode_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [WIDTH-1:0] if_pc,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [WIDTH-1:0] ex_rs1,
  output logic [WIDTH-1:0] ex_rs2,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_sel,
  output logic [WIDTH-1:0] ex_pc,
  output logic [4:0]       ex_rd_addr,
  output logic             ex_rd_we,
  output logic             ex_illegal,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush
);
  import alu_pkg::*;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [WIDTH-1:0] r_regs [32];
  logic             r_valid;

  logic [6:0]       w_opc;
  logic [4:0]       w_rd;
  logic [2:0]       w_f3;
  logic [4:0]       w_rs1_addr;
  logic [4:0]       w_rs2_addr;
  logic [6:0]       w_f7;
  logic [31:0]      w_imm_i;
  logic [31:0]      w_imm_u;
  logic [4:0]       w_sel;
  logic [31:0]      w_imm;
  logic             w_legal;
  logic [WIDTH-1:0] w_rs1_val;
  logic [WIDTH-1:0] w_rs2_val;
  logic             w_if_ready;
  logic             w_accept;

  assign w_opc      = if_instr[6:0];
  assign w_rd       = if_instr[11:7];
  assign w_f3       = if_instr[14:12];
  assign w_rs1_addr = if_instr[19:15];
  assign w_rs2_addr = if_instr[24:20];
  assign w_f7       = if_instr[31:25];
  assign w_imm_i    = {{20{if_instr[31]}}, if_instr[31:20]};
  assign w_imm_u    = {if_instr[31:12], 12'b0};

  // Stage can take a new word when empty or when EX drains the current one this cycle.
  assign w_if_ready = rst_n & (~r_valid | ex_ready);
  assign w_accept   = if_valid & w_if_ready;
  assign if_ready   = w_if_ready;
  assign ex_valid   = r_valid;

  // Instruction decode: illegal encodings fall through as add with no immediate.
  always_comb begin
    w_sel   = ALU_ADD;
    w_imm   = 32'd0;
    w_legal = 1'b0;
    case (w_opc)
      OPC_OP: begin
        if (w_f7 == 7'b0000000) begin
          w_legal = 1'b1;
          case (w_f3)
            3'b000:  w_sel = ALU_ADD;
            3'b001:  w_sel = ALU_SLL;
            3'b010:  w_sel = ALU_SLT;
            3'b011:  w_sel = ALU_SLTU;
            3'b100:  w_sel = ALU_XXOR;
            3'b101:  w_sel = ALU_SRL;
            3'b110:  w_sel = ALU_OOR;
            default: w_sel = ALU_AAND;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_legal = 1'b1;
          w_sel   = ALU_SUB;
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
          w_legal = 1'b1;
          w_sel   = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        w_imm = w_imm_i;
        case (w_f3)
          3'b000: begin w_legal = 1'b1; w_sel = ALU_ADDI;  end
          3'b010: begin w_legal = 1'b1; w_sel = ALU_SLTI;  end
          3'b011: begin w_legal = 1'b1; w_sel = ALU_SLTIU; end
          3'b100: begin w_legal = 1'b1; w_sel = ALU_XORI;  end
          3'b110: begin w_legal = 1'b1; w_sel = ALU_ORI;   end
          3'b111: begin w_legal = 1'b1; w_sel = ALU_ANDI;  end
          3'b001: begin
            if (w_f7 == 7'b0000000) begin w_legal = 1'b1; w_sel = ALU_SLLI; end
          end
          default: begin
            if (w_f7 == 7'b0000000) begin
              w_legal = 1'b1;
              w_sel   = ALU_SRLI;
            end else if (w_f7 == 7'b0100000) begin
              w_legal = 1'b1;
              w_sel   = ALU_SRAI;
            end
          end
        endcase
        if (!w_legal) begin
          w_imm = 32'd0;
        end
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_sel   = ALU_LUI;
        w_imm   = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_sel   = ALU_AUIPC;
        w_imm   = w_imm_u;
      end
      default: ;
    endcase
  end

  // Operand read; x0 is never written so it always reads zero.
`ifdef ID_WB_BYPASS_EN
  assign w_rs1_val = (wb_we && wb_addr != 5'd0 && wb_addr == w_rs1_addr) ? wb_data : r_regs[w_rs1_addr];
  assign w_rs2_val = (wb_we && wb_addr != 5'd0 && wb_addr == w_rs2_addr) ? wb_data : r_regs[w_rs2_addr];
`else
  assign w_rs1_val = r_regs[w_rs1_addr];
  assign w_rs2_val = r_regs[w_rs2_addr];
`endif

  // Register file write port; flush does not touch architectural state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_we && wb_addr != 5'd0) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // EX output register: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_imm     <= '0;
      ex_sel     <= '0;
      ex_pc      <= '0;
      ex_rd_addr <= '0;
      ex_rd_we   <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      ex_rs1     <= w_rs1_val;
      ex_rs2     <= w_rs2_val;
      ex_imm     <= w_imm;
      ex_sel     <= w_sel;
      ex_pc      <= if_pc;
      ex_rd_addr <= w_rd;
      ex_rd_we   <= w_legal & (w_rd != 5'd0);
      ex_illegal <= ~w_legal;
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
